// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: operand width, funct3 encodings, controller states
// and small decode helpers used by the multiply/divide unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] CNT_LAST = 5'd31;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input logic [2:0] f);
    return f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic a_is_signed(input logic [2:0] f);
    return f inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return f inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue logic and the multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = riscv_pkg::XLEN);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            we_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out, we_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out, we_out
  );

endinterface

// File: rtl/muldiv_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes on the way in, two's-complement
// correction of product, quotient and remainder on the way out.
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic              a_signed,
  input  logic              b_signed,
  output logic              sign_a,
  output logic              sign_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  input  logic [2*XLEN-1:0] prod,
  input  logic              neg_prod,
  output logic [2*XLEN-1:0] prod_fix,
  input  logic [XLEN-1:0]   quo,
  input  logic              neg_quo,
  output logic [XLEN-1:0]   quo_fix,
  input  logic [XLEN-1:0]   rem,
  input  logic              neg_rem,
  output logic [XLEN-1:0]   rem_fix
);

  always_comb begin
    sign_a   = a_signed & op_a[XLEN-1];
    sign_b   = b_signed & op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    prod_fix = neg_prod ? -prod : prod;
    quo_fix  = neg_quo ? -quo : quo;
    rem_fix  = neg_rem ? -rem : rem;
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add / restoring divide on magnitudes,
// fixed 33-edge latency from accepted start to the done/write-enable pulse.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for start; result/rd_out hold the last answer
//   CALC    | one radix-2 step per cycle, counter 0..31
//   DONE    | one-cycle done/we_out pulse with result valid
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q;
  funct3_e         f3_q;
  logic [4:0]      rd_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;
  logic            busy, done;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  logic [XLEN:0]   mul_sum, div_trial;
  logic [XLEN-1:0] div_diff;
  logic            div_ge, is_div;
  logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  logic [XLEN-1:0] step_hi, step_lo, res_final;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_a     (bus.op_a),
    .op_b     (bus.op_b),
    .a_signed (a_is_signed(bus.funct3)),
    .b_signed (b_is_signed(bus.funct3)),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .prod     ({mul_hi_n, mul_lo_n}),
    .neg_prod (sa_q ^ sb_q),
    .prod_fix (prod_fix),
    .quo      (div_lo_n),
    .neg_quo  ((sa_q ^ sb_q) & (|b_q)),
    .quo_fix  (quo_fix),
    .rem      (div_hi_n),
    .neg_rem  (sa_q),
    .rem_fix  (rem_fix)
  );

  // hi/lo is the product for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi_n  = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    div_trial = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_trial >= {1'b0, b_q};
    div_diff  = div_trial[XLEN-1:0] - b_q;
    div_hi_n  = div_ge ? div_diff : div_trial[XLEN-1:0];
    div_lo_n  = {lo_q[XLEN-2:0], div_ge};
    is_div    = op_is_div(f3_q);
    step_hi   = is_div ? div_hi_n : mul_hi_n;
    step_lo   = is_div ? div_lo_n : mul_lo_n;
  end

  // Divide-by-zero leaves quotient all ones and remainder = |a|; no quotient negation
  always_comb begin
    case (f3_q)
      F3_MUL:                       res_final = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_final = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              res_final = quo_fix;
      default:                      res_final = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      f3_q     <= F3_MUL;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            cnt_q <= '0;
            f3_q  <= funct3_e'(bus.funct3);
            rd_q  <= bus.rd_in;
            sa_q  <= sign_a;
            sb_q  <= sign_b;
            hi_q  <= '0;
            lo_q  <= mag_a;
            b_q   <= mag_b;
          end
        end
        ST_CALC: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            result_q <= res_final;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.we_out = done;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, control corner sequences
// and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Edges are counted from the accepting edge (k=0); outputs sampled 1ns after edge k
  // are what edge k+1 observes, so done seen after k=32 is the pulse at edge 33.
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int pulse_at, input int rst_at);
    int   ndone, first_done;
    logic busy_ok, we_ok, busy_rst;
    ndone = 0; first_done = -1; busy_ok = 1'b1; we_ok = 1'b1; busy_rst = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    bus.rd_in  = 5'($urandom);
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      bus.start = (k == pulse_at);
      rst       = (k == rst_at);
      @(posedge clk); #1;
      if (bus.we_out !== bus.done) we_ok = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      if (rst_at < 0 && bus.busy !== (k <= 32)) busy_ok = 1'b0;
      if (k == rst_at) busy_rst = bus.busy;
      if (k == 32 && rst_at < 0) begin
        chk($sformatf("%s result", name), bus.result, exp);
        chk($sformatf("%s rd_out", name), 32'(bus.rd_out), 32'(rd));
      end
    end
    rst = 1'b0; bus.start = 1'b0;
    chk($sformatf("%s we_eq_done", name), 32'(we_ok), 32'd1);
    if (rst_at < 0) begin
      chk($sformatf("%s done_edge", name), 32'(first_done), 32'd32);
      chk($sformatf("%s done_count", name), 32'(ndone), 32'd1);
      chk($sformatf("%s busy_window", name), 32'(busy_ok), 32'd1);
      chk($sformatf("%s result_hold", name), bus.result, exp);
    end else begin
      chk($sformatf("%s done_count", name), 32'(ndone), 32'd0);
      chk($sformatf("%s busy_after_rst", name), 32'(busy_rst), 32'd0);
      chk($sformatf("%s result_after_rst", name), bus.result, 32'd0);
      chk($sformatf("%s rd_out_after_rst", name), 32'(bus.rd_out), 32'd0);
    end
  endtask

  initial begin
    int ndone;
    logic [2:0]  f;
    logic [31:0] a, b;

    tbl[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    tbl[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    tbl[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
    tbl[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
    tbl[4]  = '{F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'h0000_0001};
    tbl[5]  = '{F3_DIV,    32'hFFFF_FFEC,  32'd6,         5'd6,  32'hFFFF_FFFD};
    tbl[6]  = '{F3_REM,    32'hFFFF_FFEC,  32'd6,         5'd7,  32'hFFFF_FFFE};
    tbl[7]  = '{F3_DIVU,   32'd20,         32'd6,         5'd8,  32'd3};
    tbl[8]  = '{F3_REMU,   32'd20,         32'd6,         5'd9,  32'd2};
    tbl[9]  = '{F3_DIV,    32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF};
    tbl[10] = '{F3_REMU,   32'd5,          32'd0,         5'd11, 32'd5};
    tbl[11] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
    tbl[12] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0};

    rst = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   32'(bus.busy),   32'd0);
    chk("reset done",   32'(bus.done),   32'd0);
    chk("reset we_out", 32'(bus.we_out), 32'd0);
    chk("reset result", bus.result,      32'd0);
    chk("reset rd_out", 32'(bus.rd_out), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, -1, -1);

    do_op("start_in_calc", F3_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 5, -1);
    do_op("rst_mid_calc", F3_MUL, 32'h1234, 32'h10, 5'd21, 32'd0, -1, 11);

    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.funct3 = F3_MUL; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("start_with_rst ignored", 32'(ndone), 32'd0);

    do_op("mul_after_rst", F3_MUL, 32'd3, 32'd4, 5'd22, 32'd12, -1, -1);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 300));
        default: ;
      endcase
      do_op($sformatf("rand%0d f%0d", i, f), f, a, b, 5'($urandom), ref_md(f, a, b), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-004 Port start, input, 1: request to begin an operation; sampled only in IDLE.
REQ-005 Port funct3, input, 3: RV32M op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 Port op_a, input, XLEN: rs1 value, driven from Register_File RD1.
REQ-007 Port op_b, input, XLEN: rs2 value, driven from Register_File RD2.
REQ-008 Port rd_in, input, 5: destination register index.
REQ-009 Port busy, output, 1: high from the cycle after start is accepted until done, inclusive.
REQ-010 Port done, output, 1: single-cycle completion pulse.
REQ-011 Port result, output, XLEN: final value; feeds Register_File WD3.
REQ-012 Port rd_out, output, 5: captured rd_in; feeds Register_File Address3.
REQ-013 Port we_out, output, 1: equals done; feeds Register_File WriteEnable3.

Function
REQ-014 The block SHALL implement states IDLE, CALC and DONE.
REQ-015 IDLE with start=1 SHALL, on that edge, capture funct3, rd_in, operand magnitudes and sign flags, clear the 5-bit iteration counter, and go to CALC.
REQ-016 CALC SHALL run one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide; exactly 32 cycles, counter 0..31, then DONE.
REQ-017 DONE SHALL last one cycle with done=we_out=1, then return to IDLE; done SHALL be high exactly 33 rising edges after the edge that accepted start.
REQ-018 Latency SHALL be fixed at 33 edges for every op, including divide-by-zero and overflow.
REQ-019 MUL SHALL return low 32 bits; MULH/MULHSU/MULHU SHALL return high 32 bits of the 64-bit product with signed×signed, signed×unsigned and unsigned×unsigned operands.
REQ-020 Signed ops SHALL use unsigned magnitude iteration plus a final two's-complement correction; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
REQ-021 Divide by zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = op_a.
REQ-022 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0.
REQ-023 start in CALC or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 result and rd_out SHALL hold their last value in IDLE until the next DONE; operand inputs SHALL NOT be read after capture.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, we_out=0, result=0, rd_out=0, counter=0, in any state.
REQ-026 Reset mid-CALC SHALL abort with no done or we_out pulse; start with rst=1 SHALL be ignored.

Structure
REQ-027 XLEN, the funct3 encodings and the state enum SHALL live in the shared package riscv_pkg.
REQ-028 One sub-module muldiv_sign_fix (combinational operand abs and result negate) SHALL be used; the rest SHALL be one module, 120-400 lines.

Verification
REQ-029 MUL 7 × 0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5, we_out pulse at edge 33, busy low at edge 34.
REQ-030 a=b=0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF, MUL 0x00000001.
REQ-031 a=0xFFFFFFEC (-20), b=6 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFE; a=20, b=6 -> DIVU 3, REMU 2.
REQ-032 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all at edge 33.
REQ-033 start pulsed at CALC cycle 4 -> ignored, one done only; rst at CALC cycle 10 -> busy=0 at next edge, no done; next MUL 3×4 -> 12 at edge 33.
